// File: rtl/core_encode.sv
// RV32I instruction encoder feeding a 2-entry output FIFO (latency 1).
// Optional immediate range checking is enabled by defining ENCODE_RANGE_CHECK_EN.

package core_encode_pkg;

  typedef enum logic [5:0] {
    OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI, OP_SLLI, OP_SRLI, OP_SRAI,
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU,
    OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW,
    OP_LUI, OP_AUIPC, OP_JAL, OP_JALR
  } op_e;

  typedef enum logic [2:0] {
    FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_ILL
  } fmt_e;

  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [6:0]  F7_ALT   = 7'b0100000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic        err;
  } entry_t;

endpackage

module core_encode
  import core_encode_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_err
);

  // ------------------------------------------------------------------
  // Decode: instruction format, major opcode and function fields
  // ------------------------------------------------------------------
  fmt_e       fmt;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  // NOTE: every signal assigned in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    fmt    = FMT_ILL;
    opcode = OPC_OP_IMM;
    case (in_op)
      OP_ADDI, OP_SLTI, OP_SLTIU, OP_XORI, OP_ORI, OP_ANDI: begin
        fmt    = FMT_I;
        opcode = OPC_OP_IMM;
      end
      OP_SLLI, OP_SRLI, OP_SRAI: begin
        fmt    = FMT_SH;
        opcode = OPC_OP_IMM;
      end
      OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND: begin
        fmt    = FMT_R;
        opcode = OPC_OP;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        fmt    = FMT_B;
        opcode = OPC_BRANCH;
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        fmt    = FMT_I;
        opcode = OPC_LOAD;
      end
      OP_SB, OP_SH, OP_SW: begin
        fmt    = FMT_S;
        opcode = OPC_STORE;
      end
      OP_LUI: begin
        fmt    = FMT_U;
        opcode = OPC_LUI;
      end
      OP_AUIPC: begin
        fmt    = FMT_U;
        opcode = OPC_AUIPC;
      end
      OP_JAL: begin
        fmt    = FMT_J;
        opcode = OPC_JAL;
      end
      OP_JALR: begin
        fmt    = FMT_I;
        opcode = OPC_JALR;
      end
      default: begin
        fmt    = FMT_ILL;
        opcode = OPC_OP_IMM;
      end
    endcase
  end

  always_comb begin
    funct3 = 3'd0;
    case (in_op)
      OP_SLLI, OP_SLL, OP_BNE, OP_LH, OP_SH:                   funct3 = 3'd1;
      OP_SLTI, OP_SLT, OP_LW, OP_SW:                           funct3 = 3'd2;
      OP_SLTIU, OP_SLTU:                                       funct3 = 3'd3;
      OP_XORI, OP_XOR, OP_BLT, OP_LBU:                         funct3 = 3'd4;
      OP_SRLI, OP_SRAI, OP_SRL, OP_SRA, OP_BGE, OP_LHU:        funct3 = 3'd5;
      OP_ORI, OP_OR, OP_BLTU:                                  funct3 = 3'd6;
      OP_ANDI, OP_AND, OP_BGEU:                                funct3 = 3'd7;
      default:                                                 funct3 = 3'd0;
    endcase
  end

  assign funct7 = (in_op == OP_SUB || in_op == OP_SRA || in_op == OP_SRAI) ? F7_ALT : 7'd0;

  // ------------------------------------------------------------------
  // Field assembly; unused register fields simply never reach the word
  // ------------------------------------------------------------------
  logic [31:0] raw_inst;

  always_comb begin
    raw_inst = NOP_INST;
    case (fmt)
      FMT_R:   raw_inst = {funct7, in_rs2, in_rs1, funct3, in_rd, opcode};
      FMT_I:   raw_inst = {in_imm[11:0], in_rs1, funct3, in_rd, opcode};
      FMT_SH:  raw_inst = {funct7, in_imm[4:0], in_rs1, funct3, in_rd, opcode};
      FMT_S:   raw_inst = {in_imm[11:5], in_rs2, in_rs1, funct3, in_imm[4:0], opcode};
      FMT_B:   raw_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, funct3,
                           in_imm[4:1], in_imm[11], opcode};
      FMT_U:   raw_inst = {in_imm[31:12], in_rd, opcode};
      FMT_J:   raw_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, opcode};
      default: raw_inst = NOP_INST;
    endcase
  end

  // ------------------------------------------------------------------
  // Error detection: a flagged request is replaced by ADDI x0,x0,0
  // ------------------------------------------------------------------
  logic enc_err;

`ifdef ENCODE_RANGE_CHECK_EN
  logic signed [31:0] imm_s;
  assign imm_s = $signed(in_imm);

  always_comb begin
    enc_err = 1'b0;
    case (fmt)
      FMT_I, FMT_S: enc_err = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      FMT_SH:       enc_err = (imm_s < 32'sd0) || (imm_s > 32'sd31);
      FMT_B:        enc_err = in_imm[0] || (imm_s < -32'sd4096) || (imm_s > 32'sd4094);
      FMT_U:        enc_err = (in_imm[11:0] != 12'd0);
      FMT_J:        enc_err = in_imm[0] || (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574);
      default:      enc_err = 1'b1;
    endcase
  end
`else
  assign enc_err = 1'b0;
`endif

  entry_t enc_entry;
  assign enc_entry.inst = enc_err ? NOP_INST : raw_inst;
  assign enc_entry.err  = enc_err;

  // ------------------------------------------------------------------
  // 2-entry FIFO
  // ------------------------------------------------------------------
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic [1:0] count_q, count_d;
  logic       push, pop;

  assign in_ready  = (count_q != 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = enc_entry;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
  // NOTE: the storage itself is reset because out_inst/out_err read the head entry directly and must be 0 in reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign out_inst = mem_q[rd_ptr_q].inst;
  assign out_err  = mem_q[rd_ptr_q].err;

  // ------------------------------------------------------------------
  // Protocol properties
  // ------------------------------------------------------------------
  a_count_range : assert property (@(posedge clk) disable iff (!rst_n) count_q <= 2'd2);

  a_head_stable : assert property (@(posedge clk) disable iff (!rst_n)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_inst) && $stable(out_err)));

  a_no_push_full : assert property (@(posedge clk) disable iff (!rst_n)
    (count_q == 2'd2) |-> !push);

endmodule

// File: tb/tb_core_encode.sv
// Self-checking bench for core_encode: directed cases plus randomized traffic,
// checked through an expected-word queue by an independent output monitor.

module tb_core_encode;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [31:0] in_imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic        out_err;

  core_encode dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_rd     (in_rd),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_inst  (out_inst),
    .out_err   (out_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [32:0] exp_q [$];   // {inst, err}

`ifdef ENCODE_RANGE_CHECK_EN
  localparam bit CHECKED = 1'b1;
`else
  localparam bit CHECKED = 1'b0;
`endif

  // funct3 for ops 0..36 in op-number order
  int f3_tab [37] = '{0,2,3,4,6,7,1,5,5,
                      0,0,1,2,3,4,5,5,6,7,
                      0,1,4,5,6,7,
                      0,1,2,4,5,0,1,2,
                      0,0,0,0};

  int edge_imm [16] = '{-2048, -2049, 2047, 2048, 0, 31, 32, -1,
                        4094, 4095, -4096, -4098, 1048574, 1048575, -1048576, -1048578};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder: built from the RV32I field layout with plain arithmetic.
  function automatic logic [32:0] model(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [31:0] imm);
    int          s;
    logic [31:0] w, d, r1, r2, f3;
    logic        err;
    s   = imm;
    d   = 32'(rd);
    r1  = 32'(rs1);
    r2  = 32'(rs2);
    f3  = (op <= 36) ? 32'(f3_tab[op]) : 32'd0;
    err = 1'b0;
    if (op <= 5) begin
      w   = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'h13;
      err = (s < -2048) || (s > 2047);
    end else if (op <= 8) begin
      w   = ((op == 8) ? 32'h4000_0000 : 32'd0) | ((imm & 32'd31) << 20) | (r1 << 15) |
            (f3 << 12) | (d << 7) | 32'h13;
      err = (s < 0) || (s > 31);
    end else if (op <= 18) begin
      w = ((op == 10 || op == 16) ? 32'h4000_0000 : 32'd0) | (r2 << 20) | (r1 << 15) |
          (f3 << 12) | (d << 7) | 32'h33;
    end else if (op <= 24) begin
      w   = (((imm >> 12) & 32'd1) << 31) | (((imm >> 5) & 32'd63) << 25) | (r2 << 20) |
            (r1 << 15) | (f3 << 12) | (((imm >> 1) & 32'd15) << 8) |
            (((imm >> 11) & 32'd1) << 7) | 32'h63;
      err = (imm[0] == 1'b1) || (s < -4096) || (s > 4094);
    end else if (op <= 29) begin
      w   = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f3 << 12) | (d << 7) | 32'h03;
      err = (s < -2048) || (s > 2047);
    end else if (op <= 32) begin
      w   = (((imm >> 5) & 32'd127) << 25) | (r2 << 20) | (r1 << 15) | (f3 << 12) |
            ((imm & 32'd31) << 7) | 32'h23;
      err = (s < -2048) || (s > 2047);
    end else if (op <= 34) begin
      w   = (imm & 32'hFFFF_F000) | (d << 7) | ((op == 33) ? 32'h37 : 32'h17);
      err = (imm & 32'hFFF) != 0;
    end else if (op == 35) begin
      w   = (((imm >> 20) & 32'd1) << 31) | (((imm >> 1) & 32'd1023) << 21) |
            (((imm >> 11) & 32'd1) << 20) | (((imm >> 12) & 32'd255) << 12) | (d << 7) | 32'h6F;
      err = (imm[0] == 1'b1) || (s < -1048576) || (s > 1048574);
    end else if (op == 36) begin
      w   = ((imm & 32'hFFF) << 20) | (r1 << 15) | (d << 7) | 32'h67;
      err = (s < -2048) || (s > 2047);
    end else begin
      w   = 32'h13;
      err = 1'b1;
    end
    if (!CHECKED) err = 1'b0;
    if (err) w = 32'h13;
    return {w, err};
  endfunction

  // Present a request until accepted; record the expected word at the accepting edge.
  task automatic send(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [31:0] imm, input logic [32:0] exp);
    int waited = 0;
    in_valid = 1'b1;
    in_op    = 6'(op);
    in_rd    = rd;
    in_rs1   = rs1;
    in_rs2   = rs2;
    in_imm   = imm;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        break;
      end
      waited++;
      if (waited > 200) begin
        check("accept_timeout", 32'(waited), 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_model(input int op, input logic [4:0] rd, input logic [4:0] rs1,
                            input logic [4:0] rs2, input logic [31:0] imm);
    send(op, rd, rs1, rs2, imm, model(op, rd, rs1, rs2, imm));
  endtask

  task automatic drain();
    int waited = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("drain_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    exp_q.delete();
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_imm();
    logic [31:0] v;
    case ($urandom_range(0, 3))
      0:       v = $urandom;
      1:       v = 32'($signed($urandom_range(0, 10000)) - 5000);
      2:       v = 32'(edge_imm[$urandom_range(0, 15)]);
      default: v = $urandom & 32'hFFFF_F000;
    endcase
    return v;
  endfunction

  // Monitor: compares every consumed word in order and checks the head holds while stalled.
  logic        held;
  logic [31:0] held_inst;
  logic        held_err;
  initial begin
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          check("stall_valid", 32'(out_valid), 32'd1);
          check("stall_inst", out_inst, held_inst);
          check("stall_err", 32'(out_err), 32'(held_err));
        end
        if (out_valid && out_ready) begin
          check("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            logic [32:0] e;
            e = exp_q.pop_front();
            check("out_inst", out_inst, e[32:1]);
            check("out_err", 32'(out_err), 32'(e[0]));
          end
        end
        held      = out_valid && !out_ready;
        held_inst = out_inst;
        held_err  = out_err;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bit rand_done;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_op     = '0;
    in_rd     = '0;
    in_rs1    = '0;
    in_rs2    = '0;
    in_imm    = '0;
    out_ready = 1'b1;
    rand_done = 1'b0;

    #3;
    check("init_out_valid", 32'(out_valid), 32'd0);
    check("init_out_inst", out_inst, 32'd0);
    check("init_out_err", 32'(out_err), 32'd0);
    check("init_in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // LUI with latency-1 check
    check("empty_before_lui", 32'(out_valid), 32'd0);
    send(33, 5'd1, 5'd9, 5'd17, 32'hFAAA_F000, {32'hFAAA_F0B7, 1'b0});
    check("lui_latency", 32'(out_valid), 32'd1);
    send(35, 5'd3, 5'd31, 5'd30, 32'h0009_97FE, {32'h7FE9_91EF, 1'b0});
    send(16, 5'd21, 5'd7, 5'd1, 32'h1234_5678, {32'h4013_DAB3, 1'b0});
`ifdef ENCODE_RANGE_CHECK_EN
    send(0, 5'd1, 5'd0, 5'd0, 32'd2048, {32'h0000_0013, 1'b1});
    send(19, 5'd0, 5'd2, 5'd3, 32'd3, {32'h0000_0013, 1'b1});
`else
    send(0, 5'd1, 5'd0, 5'd0, 32'd2048, {32'h8000_0093, 1'b0});
`endif
    send(50, 5'd5, 5'd6, 5'd7, 32'h0000_0ABC, {32'h0000_0013, CHECKED});
    drain();

    // Back-to-back with a stalled consumer
    out_ready = 1'b0;
    send_model(9, 5'd1, 5'd2, 5'd3, 32'd0);
    send_model(2, 5'd4, 5'd5, 5'd6, 32'hFFFF_FFF0);
    in_valid = 1'b1;
    in_op    = 6'd27;
    in_rd    = 5'd7;
    in_rs1   = 5'd8;
    in_rs2   = 5'd9;
    in_imm   = 32'd100;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("full_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send_model(27, 5'd7, 5'd8, 5'd9, 32'd100);
    drain();

    // Reset with two words buffered
    out_ready = 1'b0;
    send_model(17, 5'd10, 5'd11, 5'd12, 32'd0);
    send_model(30, 5'd13, 5'd14, 5'd15, 32'd40);
    pulse_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_stale_word", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send_model(36, 5'd2, 5'd3, 5'd4, 32'hFFFF_F800);
    drain();

    // Randomized traffic with a randomly stalling consumer
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          int op;
          op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(37, 63)) : int'($urandom_range(0, 36));
          send_model(op, 5'($urandom), 5'($urandom), 5'($urandom), rand_imm());
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/core_encode.md
CORE_ENCODE -- requirements
Module: core_encode

Interface
REQ-001 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have port rst_n  in  1  reset; asynchronous, active-low.
REQ-003 SHALL have port in_valid  in  1  request present.
REQ-004 SHALL have port in_ready  out  1  request accepted this cycle when in_valid=1.
REQ-005 SHALL have port in_op  in  6  op select: 0-8 ADDI,SLTI,SLTIU,XORI,ORI,ANDI,SLLI,SRLI,SRAI; 9-18 ADD,SUB,SLL,SLT,SLTU,XOR,SRL,SRA,OR,AND; 19-24 BEQ,BNE,BLT,BGE,BLTU,BGEU; 25-32 LB,LH,LW,LBU,LHU,SB,SH,SW; 33 LUI; 34 AUIPC; 35 JAL; 36 JALR; 37-63 illegal.
REQ-006 SHALL have ports in_rd, in_rs1, in_rs2  in  5 each  register numbers.
REQ-007 SHALL have port in_imm  in  32  immediate as a signed byte value (U-type: final value, low 12 bits zero).
REQ-008 SHALL have port out_valid  out  1  out_inst holds an encoded word.
REQ-009 SHALL have port out_ready  in  1  consumer takes word when out_valid=1.
REQ-010 SHALL have port out_inst  out  32  RV32I instruction word.
REQ-011 SHALL have port out_err  out  1  word was substituted due to an error; qualified by out_valid.

Function
REQ-012 SHALL encode combinationally at acceptance and push {inst,err} into a 2-entry FIFO; out_* SHALL present the FIFO head.
REQ-013 SHALL accept (push) when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-014 SHALL drive in_ready = (count < 2), independent of out_ready; no push at count 2 even if a pop occurs in the same cycle.
REQ-015 SHALL assert out_valid the cycle after the first push into an empty FIFO (latency 1); no combinational path from in_* to out_*.
REQ-016 SHALL handle simultaneous push and pop at count 1 by keeping count 1 and presenting the new word the next cycle.
REQ-017 SHALL preserve out_inst/out_err stable while out_valid && !out_ready.
REQ-018 SHALL form fields per RV32I: R {f7,rs2,rs1,f3,rd,op}; I {imm[11:0],rs1,f3,rd,op}; shifts {f7,imm[4:0],rs1,f3,rd,op}; S {imm[11:5],rs2,rs1,f3,imm[4:0],op}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],op}; U {imm[31:12],rd,op}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,op}.
REQ-019 SHALL use funct7 0100000 for SUB, SRA, SRAI; 0000000 otherwise.
REQ-020 SHALL ignore register fields unused by the selected format.
REQ-021 SHALL emit 0x00000013 (ADDI x0,x0,0) for illegal in_op, regardless of configuration.
REQ-022 SHALL maintain pointers with wrap-around over 2 entries; count range 0..2.

Reset
REQ-023 SHALL on rst_n=0, immediately and regardless of clk: count=0, pointers=0, out_valid=0, out_inst=0, out_err=0; in_ready SHALL be 1 while in reset.
REQ-024 SHALL discard buffered words on reset asserted mid-operation; no word SHALL be emitted after release unless it is pushed after release.

Configuration
REQ-025 SHALL, with ENCODE_RANGE_CHECK_EN defined, flag errors: I/load/JALR/S imm outside -2048..2047; shift imm outside 0..31; B imm odd or outside -4096..4094; U imm[11:0]!=0; J imm odd or outside -1048576..1048574; illegal op. On error: word=0x00000013, err=1.
REQ-026 SHALL, without ENCODE_RANGE_CHECK_EN, perform no range checks, truncate imm bits per REQ-018, and tie out_err to 0.

Verification
REQ-027 SHALL cover: LUI rd=1 imm=0xFAAAF000, out_ready=1 -> out_inst=0xFAAAF0B7 one cycle after accept, out_err=0.
REQ-028 SHALL cover: JAL rd=3 imm=0x000997FE -> 0x7FE991EF; SRA rd=21 rs1=7 rs2=1 -> 0x4013DAB3.
REQ-029 SHALL cover: out_ready=0, three back-to-back requests -> in_ready low after two accepts; third accepted only after a pop; output order preserved, head stable while stalled.
REQ-030 SHALL cover (macro defined): ADDI imm=2048 -> 0x00000013, out_err=1; BEQ imm=3 -> out_err=1; (macro undefined): ADDI imm=2048 rd=1 -> 0x80000093, out_err=0.
REQ-031 SHALL cover: in_op=50 -> 0x00000013 in both configurations.
REQ-032 SHALL cover: two words buffered, rst_n pulsed low between edges -> out_valid=0 at once; no stale word after release.
